// File: rtl/present_sbox_sched.sv
// present_sbox_sched: schedules the nibbles of a three-share PRESENT state
// through an external masked S-box pipeline of fixed latency SBOX_LAT.
// One nibble per share is launched in every cycle where fresh randomness
// is offered. A valid/index shift register tracks each launch so that the
// pipeline result lands in the right nibble of each result share. Share
// domains are kept strictly separate: every datapath touches one share only.
module present_sbox_sched #(
  parameter int SBOX_LAT = 5,
  parameter int NIB      = 16
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4*NIB-1:0]  state1_i,
  input  logic [4*NIB-1:0]  state2_i,
  input  logic [4*NIB-1:0]  state3_i,
  input  logic [23:0]       rnd_i,
  input  logic              rnd_valid_i,
  output logic              rnd_ready_o,
  output logic [3:0]        sb_in1_o,
  output logic [3:0]        sb_in2_o,
  output logic [3:0]        sb_in3_o,
  output logic [23:0]       sb_r_o,
  input  logic [3:0]        sb_out1_i,
  input  logic [3:0]        sb_out2_i,
  input  logic [3:0]        sb_out3_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [4*NIB-1:0]  state1_o,
  output logic [4*NIB-1:0]  state2_o,
  output logic [4*NIB-1:0]  state3_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  fsm_t            fsm;
  fsm_t            fsm_nxt;

  // share-domain input and result registers
  logic [W-1:0]    share1;
  logic [W-1:0]    share2;
  logic [W-1:0]    share3;
  logic [W-1:0]    res1;
  logic [W-1:0]    res2;
  logic [W-1:0]    res3;

  logic [IW-1:0]   iss_cnt;
  logic [IW-1:0]   col_cnt;

  // launch tracking pipeline: index 0 is the youngest launch
  logic [SBOX_LAT-1:0] pipe_v;
  logic [IW-1:0]       pipe_idx [SBOX_LAT];

  logic            err;

  logic            accept;
  logic            launch;
  logic            capture;
  logic            pipe_busy;
  logic            last_issue;
  logic            last_collect;
  logic [IW-1:0]   cap_idx;
  logic [3:0]      nib1;
  logic [3:0]      nib2;
  logic [3:0]      nib3;

  // Decode the per-cycle control events from state, counters and pipeline
  always_comb begin
    accept       = (fsm == IDLE) && in_valid_i;
    launch       = (fsm == ISSUE) && rnd_valid_i;
    capture      = pipe_v[SBOX_LAT-1];
    cap_idx      = pipe_idx[SBOX_LAT-1];
    pipe_busy    = |pipe_v;
    last_issue   = (iss_cnt == IW'(NIB - 1));
    last_collect = (col_cnt == IW'(NIB - 1));
  end

  // Select nibble iss_cnt of each share; AND-OR mux stays within one share
  always_comb begin
    nib1 = 4'h0;
    nib2 = 4'h0;
    nib3 = 4'h0;
    for (int k = 0; k < NIB; k++) begin
      nib1 = nib1 | (share1[4*k +: 4] & {4{iss_cnt == IW'(k)}});
      nib2 = nib2 | (share2[4*k +: 4] & {4{iss_cnt == IW'(k)}});
      nib3 = nib3 | (share3[4*k +: 4] & {4{iss_cnt == IW'(k)}});
    end
  end

  // Next-state logic for the IDLE/ISSUE/DRAIN/DONE sequencer
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: begin
        if (in_valid_i) begin
          fsm_nxt = ISSUE;
        end else begin
          fsm_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (launch && last_issue) begin
          fsm_nxt = DRAIN;
        end else begin
          fsm_nxt = ISSUE;
        end
      end
      DRAIN: begin
        if (capture && last_collect) begin
          fsm_nxt = DONE;
        end else begin
          fsm_nxt = DRAIN;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          fsm_nxt = IDLE;
        end else begin
          fsm_nxt = DONE;
        end
      end
      default: begin
        fsm_nxt = IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  // Capture the three input shares into their own registers on acceptance
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      share1 <= {W{1'b0}};
      share2 <= {W{1'b0}};
      share3 <= {W{1'b0}};
    end else if (accept) begin
      share1 <= state1_i;
      share2 <= state2_i;
      share3 <= state3_i;
    end
  end

  // Issue and collect counters, restarted for every accepted state
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      iss_cnt <= {IW{1'b0}};
      col_cnt <= {IW{1'b0}};
    end else if (accept) begin
      iss_cnt <= {IW{1'b0}};
      col_cnt <= {IW{1'b0}};
    end else begin
      if (launch) begin
        iss_cnt <= iss_cnt + IW'(1);
      end
      if (capture) begin
        col_cnt <= col_cnt + IW'(1);
      end
    end
  end

  // Shift a valid bit and nibble index along with each launched nibble
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pipe_v <= {SBOX_LAT{1'b0}};
      for (int i = 0; i < SBOX_LAT; i++) begin
        pipe_idx[i] <= {IW{1'b0}};
      end
    end else begin
      pipe_v[0]   <= launch;
      pipe_idx[0] <= iss_cnt;
      for (int i = 1; i < SBOX_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Write each share's S-box result into the nibble its launch came from
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      res1 <= {W{1'b0}};
      res2 <= {W{1'b0}};
      res3 <= {W{1'b0}};
    end else if (capture) begin
      for (int k = 0; k < NIB; k++) begin
        if (cap_idx == IW'(k)) begin
          res1[4*k +: 4] <= sb_out1_i;
          res2[4*k +: 4] <= sb_out2_i;
          res3[4*k +: 4] <= sb_out3_i;
        end
      end
    end
  end

  // Sticky randomness-underflow flag: pipeline needed randomness, none offered
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (pipe_busy && !rnd_valid_i) begin
      err <= 1'b1;
    end
  end

  // Nibbles are only driven in launch cycles; otherwise the bus idles at zero
  assign sb_in1_o    = launch ? nib1 : 4'h0;
  assign sb_in2_o    = launch ? nib2 : 4'h0;
  assign sb_in3_o    = launch ? nib3 : 4'h0;
  assign sb_r_o      = rnd_i;
  assign rnd_ready_o = launch | pipe_busy;

  assign in_ready_o  = (fsm == IDLE);
  assign out_valid_o = (fsm == DONE);
  assign busy_o      = (fsm != IDLE);
  assign err_o       = err;
  assign state1_o    = res1;
  assign state2_o    = res2;
  assign state3_o    = res3;

endmodule

// File: tb/tb_present_sbox_sched.sv
// Testbench for present_sbox_sched: a behavioural masked S-box pipeline of
// latency LAT feeds the scheduler; expected result shares are queued at
// acceptance and compared when out_valid_o appears.
module tb_present_sbox_sched;

  localparam int LAT = 5;
  localparam int NIB = 16;

  logic         clk;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [63:0]  state1_i, state2_i, state3_i;
  logic [23:0]  rnd_i;
  logic         rnd_valid_i;
  logic         rnd_ready_o;
  logic [3:0]   sb_in1_o, sb_in2_o, sb_in3_o;
  logic [23:0]  sb_r_o;
  logic [3:0]   sb_out1_i, sb_out2_i, sb_out3_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [63:0]  state1_o, state2_o, state3_o;
  logic         busy_o;
  logic         err_o;

  int           ntest;
  int           nfail;
  int           nl;
  int           got;
  logic [7:0]   cur_seed;
  logic [191:0] sb_q [$];
  logic [11:0]  pipe [LAT];

  localparam logic [63:0] V0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] V1 = 64'hFEDCBA9876543210;
  localparam logic [63:0] M1 = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] M2 = 64'h6A09E667F3BCC908;

  present_sbox_sched #(.SBOX_LAT(LAT), .NIB(NIB)) dut (
    .clk(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .state1_i(state1_i), .state2_i(state2_i), .state3_i(state3_i),
    .rnd_i(rnd_i), .rnd_valid_i(rnd_valid_i), .rnd_ready_o(rnd_ready_o),
    .sb_in1_o(sb_in1_o), .sb_in2_o(sb_in2_o), .sb_in3_o(sb_in3_o),
    .sb_r_o(sb_r_o),
    .sb_out1_i(sb_out1_i), .sb_out2_i(sb_out2_i), .sb_out3_i(sb_out3_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .state1_o(state1_o), .state2_o(state2_o), .state3_o(state3_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] sbox64(input logic [63:0] v);
    logic [63:0] r;
    r = 64'h0;
    for (int k = 0; k < NIB; k++) r[4*k +: 4] = sbox(v[4*k +: 4]);
    return r;
  endfunction

  // randomness word the bench offers for the k-th launch of an operation
  function automatic logic [23:0] rnd_word(input int k, input logic [7:0] seed);
    logic [7:0] kk;
    kk = 8'(k);
    return {seed ^ (kk * 8'd37), kk + seed * 8'd3, (kk * 8'd11) ^ {seed[3:0], seed[7:4]}};
  endfunction

  // share-domain model of one masked S-box evaluation: {out1, out2, out3}
  function automatic logic [11:0] sbox_model(input logic [3:0] a, b, c, input logic [23:0] r);
    logic [3:0] o1, o2, o3;
    o2 = b ^ r[3:0];
    o3 = c ^ r[7:4];
    o1 = sbox(a ^ b ^ c) ^ o2 ^ o3;
    return {o1, o2, o3};
  endfunction

  function automatic logic [191:0] expect_res(input logic [63:0] s1, s2, s3, input logic [7:0] seed);
    logic [63:0] e1, e2, e3;
    logic [11:0] o;
    e1 = 64'h0; e2 = 64'h0; e3 = 64'h0;
    for (int k = 0; k < NIB; k++) begin
      o = sbox_model(s1[4*k +: 4], s2[4*k +: 4], s3[4*k +: 4], rnd_word(k, seed));
      e1[4*k +: 4] = o[11:8];
      e2[4*k +: 4] = o[7:4];
      e3[4*k +: 4] = o[3:0];
    end
    return {e1, e2, e3};
  endfunction

  // external S-box pipeline: LAT cycles from sb_in/sb_r to sb_out
  always @(posedge clk) begin
    pipe[0] <= sbox_model(sb_in1_o, sb_in2_o, sb_in3_o, sb_r_o);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {sb_out1_i, sb_out2_i, sb_out3_i} = pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // offer a shared state in IDLE and queue its expected result shares
  task automatic accept(input logic [63:0] v, m1, m2, input logic [7:0] seed);
    logic [63:0] s1;
    bit ok;
    s1 = v ^ m1 ^ m2;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready_o;
    end
    check("accept_ready", 64'(ok), 64'd1);
    state1_i = s1; state2_i = m1; state3_i = m2;
    in_valid_i = 1'b1;
    rnd_valid_i = 1'b0;
    sb_q.push_back(expect_res(s1, m1, m2, seed));
    cur_seed = seed;
    nl = 0;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    state1_i = ~s1; state2_i = m1 ^ 64'h1111_1111_1111_1111; state3_i = ~m2;
  endtask

  // mode 0: randomness every cycle except ba/bb; mode 1: one launch per LAT+1
  task automatic drive(input int mode, input int ba, input int bb, output int cyc);
    bit rv;
    cyc = -1;
    for (int c = 0; c < 300 && cyc < 0; c++) begin
      @(negedge clk);
      if (out_valid_o) begin
        cyc = c;
      end else begin
        rv = (mode == 1) ? ((c % (LAT + 1) == 0) && (nl < NIB)) : (c != ba && c != bb);
        rnd_valid_i = rv;
        rnd_i = rv ? rnd_word(nl, cur_seed) : (24'h3C3C3C ^ 24'(c));
        in_valid_i = (c == 2);
        if (rv && nl < NIB) nl++;
        if (c == ba) begin
          #1;
          check("bubble_sb_in", 64'({sb_in1_o, sb_in2_o, sb_in3_o}), 64'd0);
          check("bubble_rnd_ready", 64'(rnd_ready_o), 64'd1);
        end
        if (c == 1) begin
          #1;
          check("sb_r_follow", 64'(sb_r_o), 64'(rnd_i));
        end
      end
    end
    in_valid_i = 1'b0;
    rnd_valid_i = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int cyc, input int exp_cyc, input int exp_err,
                           input logic [63:0] exp_xor, input bit hold);
    logic [191:0] e;
    e = 192'h0;
    check({tag, "_queue"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    check({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_share1"}, state1_o, e[191:128]);
    check({tag, "_share2"}, state2_o, e[127:64]);
    check({tag, "_share3"}, state3_o, e[63:0]);
    check({tag, "_unshared"}, state1_o ^ state2_o ^ state3_o, exp_xor);
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    if (exp_err >= 0) check({tag, "_err"}, 64'(err_o), 64'(exp_err));
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        in_valid_i = (i % 2 == 0);
        state1_i = {$urandom, $urandom};
        state2_i = {$urandom, $urandom};
        @(negedge clk);
        check({tag, "_hold_valid"}, 64'(out_valid_o), 64'd1);
        check({tag, "_hold_in_ready"}, 64'(in_ready_o), 64'd0);
        check({tag, "_hold_s1"}, state1_o, e[191:128]);
        check({tag, "_hold_s2"}, state2_o, e[127:64]);
        check({tag, "_hold_s3"}, state3_o, e[63:0]);
      end
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    check({tag, "_idle_in_ready"}, 64'(in_ready_o), 64'd1);
    check({tag, "_idle_out_valid"}, 64'(out_valid_o), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_idle_result"}, state1_o, e[191:128]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready_o), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_err"}, 64'(err_o), 64'd0);
    check({tag, "_sb_in"}, 64'({sb_in1_o, sb_in2_o, sb_in3_o}), 64'd0);
    check({tag, "_rnd_ready"}, 64'(rnd_ready_o), 64'd0);
    check({tag, "_result"}, state1_o | state2_o | state3_o, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ntest = 0; nfail = 0; nl = 0; cur_seed = 8'h00;
    rst_i = 1'b1;
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    state1_i = 64'h0; state2_i = 64'h0; state3_i = 64'h0;
    rnd_i = 24'h0; rnd_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_i = 1'b0;

    // unbroken randomness, then 10-cycle back-pressure in DONE
    accept(V0, M1, M2, 8'h11);
    drive(0, -1, -1, got);
    finish_op("unbroken", got, 16 + LAT, 0, 64'hC56B90AD3EF84712, 1'b1);

    // bubbles on cycles 3 and 7 with nibbles in flight
    accept(V0, M1, M2, 8'h22);
    drive(0, 3, 7, got);
    finish_op("bubbles", got, 18 + LAT, 1, 64'hC56B90AD3EF84712, 1'b0);

    // one launch every LAT+1 cycles
    accept(V0, M2, M1, 8'h33);
    drive(1, -1, -1, got);
    finish_op("spaced", got, 15 * (LAT + 1) + LAT + 1, -1, 64'hC56B90AD3EF84712, 1'b0);

    // reset at cycle 8 of ISSUE, new state two cycles after release
    accept(V1, M1, ~M2, 8'h44);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rnd_valid_i = 1'b1;
      rnd_i = rnd_word(nl, cur_seed);
      nl++;
    end
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check_reset_state("midrst");
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    @(negedge clk);
    rst_i = 1'b0;
    rnd_valid_i = 1'b0;
    @(negedge clk);
    accept(V0 ^ 64'h5A5A_0F0F_A5A5_F0F0, M2, M1 ^ 64'h1234_5678_9ABC_DEF0, 8'h55);
    drive(0, -1, -1, got);
    finish_op("after_rst", got, 16 + LAT, 0, sbox64(V0 ^ 64'h5A5A_0F0F_A5A5_F0F0), 1'b0);

    // all-zero value with all-ones masks
    accept(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h66);
    drive(0, -1, -1, got);
    finish_op("zero", got, 16 + LAT, 0, 64'hCCCC_CCCC_CCCC_CCCC, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
